// File: rtl/long_accumulator_frame_ctrl.sv
// Frame sequencer for a long accumulator: gates operand beats, clears between frames,
// tracks accumulator latency with a tag pipe and captures frame sums in a small FIFO.
// Optional LONG_ACC_BEAT_COUNT_EN adds res_beats (beats in the frame at FIFO head).
module long_accumulator_frame_ctrl #(
  parameter int SIZE        = 3474,
  parameter int ACC_LATENCY = 6,
  parameter int RES_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            sclear_n,
  input  logic [SIZE-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [SIZE-1:0] acc_din,
  output logic            acc_sclear,
  input  logic [SIZE-1:0] acc_dout,
  output logic [SIZE-1:0] res_data,
  output logic            res_valid,
  input  logic            res_ready
`ifdef LONG_ACC_BEAT_COUNT_EN
  , output logic [31:0]   res_beats
`endif
);
  localparam int CW = $clog2(RES_DEPTH + 1) + 1;
  localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RES_DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [ACC_LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0]          inflight_q, inflight_d, cnt_q, cnt_d;
  logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [SIZE-1:0]        mem_q [RES_DEPTH];
  logic [SIZE-1:0]        mem_d [RES_DEPTH];
  logic                   accept, acc_last, push, pop, credit_ok;

`ifdef LONG_ACC_BEAT_COUNT_EN
  logic [31:0] beat_q, beat_d, beat_inc;
  logic [31:0] btag_q [ACC_LATENCY];
  logic [31:0] btag_d [ACC_LATENCY];
  logic [31:0] bmem_q [RES_DEPTH];
  logic [31:0] bmem_d [RES_DEPTH];
`endif

  always_comb begin
    // Frames in flight plus stored results never exceed the FIFO, so a push always fits.
    credit_ok  = (inflight_q + cnt_q) < CW'(RES_DEPTH);
    in_ready   = sclear_n && (state_q == S_RUN) && credit_ok;
    accept     = in_valid && in_ready;
    acc_last   = accept && in_last;
    acc_din    = accept ? in_data : '0;
    acc_sclear = !sclear_n || (state_q == S_CLEAR);
    res_valid  = sclear_n && (cnt_q != '0);
    res_data   = res_valid ? mem_q[rd_q] : '0;
    push       = tag_q[ACC_LATENCY-1];
    pop        = res_valid && res_ready;

    state_d = state_q;
    case (state_q)
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (acc_last) state_d = S_CLEAR;
      default: state_d = S_CLEAR;
    endcase

    tag_d    = '0;
    tag_d[0] = acc_last;
    for (int i = 1; i < ACC_LATENCY; i++) tag_d[i] = tag_q[i-1];

    inflight_d = inflight_q + CW'(acc_last) - CW'(push);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (push) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + PW'(1);
    if (pop)  rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + PW'(1);

    mem_d = mem_q;
    if (push) mem_d[wr_q] = acc_dout;

`ifdef LONG_ACC_BEAT_COUNT_EN
    beat_inc = (beat_q == '1) ? beat_q : beat_q + 32'd1;
    beat_d   = beat_q;
    if (state_q == S_CLEAR) beat_d = '0;
    else if (accept)        beat_d = beat_inc;
    btag_d[0] = acc_last ? beat_inc : '0;
    for (int i = 1; i < ACC_LATENCY; i++) btag_d[i] = btag_q[i-1];
    bmem_d = bmem_q;
    if (push) bmem_d[wr_q] = btag_q[ACC_LATENCY-1];
    res_beats = res_valid ? bmem_q[rd_q] : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!sclear_n) begin
      state_q    <= S_CLEAR;
      tag_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
`ifdef LONG_ACC_BEAT_COUNT_EN
      beat_q     <= '0;
      btag_q     <= '{default: '0};
`endif
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
`ifdef LONG_ACC_BEAT_COUNT_EN
      beat_q     <= beat_d;
      btag_q     <= btag_d;
`endif
    end
  end

  // Result storage needs no reset: res_data/res_beats are masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
`ifdef LONG_ACC_BEAT_COUNT_EN
    bmem_q <= bmem_d;
`endif
  end

endmodule
